// File: rtl/alu_op_decoder.sv
// Instruction decode stage: maps opcodes to ALU controls and delivers them through a 2-entry skid buffer.
// Optional ILLEGAL_TRAP_EN adds a sticky trap that blocks new instructions after an illegal opcode.
module alu_op_decoder #(
  parameter int INSN_W = 9,
  parameter int OPND_W = INSN_W - 4,
  parameter int CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_insn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_alu_op,
  output logic [1:0]        out_cmp,
  output logic              out_neg,
  output logic [OPND_W-1:0] out_operand,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_cnt,
  output logic              trap,
  input  logic              trap_clr
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_LSH = 3'd1;
  localparam logic [2:0] OP_RSH = 3'd2;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_CLR = 3'd6;
  localparam logic [2:0] OP_OR  = 3'd7;

  localparam logic [1:0] CMP_NONE = 2'b00;
  localparam logic [1:0] CMP_GEQ  = 2'b01;
  localparam logic [1:0] CMP_EQ   = 2'b10;
  localparam logic [1:0] CMP_NEQ  = 2'b11;

  typedef struct packed {
    logic [2:0]        alu_op;
    logic [1:0]        cmp;
    logic              neg;
    logic              illegal;
    logic [OPND_W-1:0] operand;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{alu_op: OP_CLR, cmp: CMP_NONE, neg: 1'b0,
                                     illegal: 1'b0, operand: '0};

  logic [3:0] opcode;
  entry_t     dec;
  entry_t     head;
  entry_t     tail;
  logic [1:0] occ;
  logic       push;
  logic       pop;

  assign opcode = in_insn[INSN_W-1 -: 4];

  always_comb begin
    dec         = RESET_ENTRY;
    dec.operand = in_insn[OPND_W-1:0];
    case (opcode)
      4'b0000: dec.alu_op = OP_LSH;
      4'b0001: dec.alu_op = OP_RSH;
      4'b0010: dec.alu_op = OP_AND;
      4'b0011: dec.alu_op = OP_OR;
      4'b1011: dec.alu_op = OP_ADD;
      4'b1000: begin dec.alu_op = OP_SUB; dec.cmp = CMP_GEQ; end
      4'b1001: begin dec.alu_op = OP_SUB; dec.cmp = CMP_EQ;  end
      4'b1101: begin dec.alu_op = OP_SUB; dec.cmp = CMP_NEQ; end
      4'b1010: begin dec.alu_op = OP_SUB; dec.neg = 1'b1;    end
      default: begin dec.alu_op = OP_CLR; dec.illegal = 1'b1; end
    endcase
  end

  // Ready depends only on registered state, so no out_ready -> in_ready path exists.
  assign in_ready  = (occ != 2'd2) & ~trap;
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      occ  <= 2'd0;
      head <= RESET_ENTRY;
      tail <= RESET_ENTRY;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= dec;
          else             tail <= dec;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        // Push and pop together only happen at occupancy 1: the new word becomes head.
        2'b11:   head <= dec;
        default: ;
      endcase
    end
  end

  assign out_alu_op  = head.alu_op;
  assign out_cmp     = head.cmp;
  assign out_neg     = head.neg;
  assign out_operand = head.operand;
  assign out_illegal = head.illegal;

  always_ff @(posedge Clk) begin
    if (Reset)
      illegal_cnt <= '0;
    else if (push && dec.illegal && (illegal_cnt != {CNT_W{1'b1}}))
      illegal_cnt <= illegal_cnt + 1'b1;
  end

`ifdef ILLEGAL_TRAP_EN
  // A trap-setting accept wins over a simultaneous clear.
  always_ff @(posedge Clk) begin
    if (Reset)
      trap <= 1'b0;
    else if (push && dec.illegal)
      trap <= 1'b1;
    else if (trap_clr)
      trap <= 1'b0;
  end
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr;
  assign trap = 1'b0;
`endif

endmodule
